// File: rtl/mem_writer.sv
// Write-side controller: buffers write requests in a small FIFO and drains them, or block-fills a range.
// Optional WR_CNT_EN adds a saturating count of issued writes on wr_count.
module mem_writer #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW:0]   fill_len,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          fill_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
`ifdef WR_CNT_EN
    ,
    output logic [7:0]    wr_count
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

    req_t           fifo [DEPTH];
    logic [PW-1:0]  wptr, rptr;
    logic [PW:0]    count;
    logic           full, empty, push, pop;
    req_t           head;

    state_t         state, state_n;
    logic [AW-1:0]  ptr, ptr_n;
    logic [AW:0]    rem, rem_n;
    logic [DW-1:0]  fdat, fdat_n;
    logic           we_n, done_n;
    logic [AW-1:0]  addr_n;
    logic [DW-1:0]  data_n;
    logic           last_pop;

    assign full      = (count == DEPTH[PW:0]);
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = fifo[rptr];
    assign busy      = (state != IDLE) || !empty;
    // FIFO goes empty at this edge only if nothing refills it
    assign last_pop  = (count == {{PW{1'b0}}, 1'b1}) && !push;

    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= '{addr: req_addr, data: req_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        we_n    = 1'b0;
        done_n  = 1'b0;
        addr_n  = mem_addr;
        data_n  = mem_wdata;
        ptr_n   = ptr;
        rem_n   = rem;
        fdat_n  = fdat;
        case (state)
            IDLE: begin
                if (fill_start && fill_len != '0 && empty) begin
                    we_n    = 1'b1;
                    addr_n  = fill_base;
                    data_n  = fill_data;
                    ptr_n   = fill_base + 1'b1;
                    rem_n   = fill_len - 1'b1;
                    fdat_n  = fill_data;
                    if (fill_len == {{AW{1'b0}}, 1'b1}) done_n = 1'b1;
                    else                                state_n = FILL;
                end else if (!empty) begin
                    pop     = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = head.addr;
                    data_n  = head.data;
                    state_n = last_pop ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                pop    = 1'b1;
                we_n   = 1'b1;
                addr_n = head.addr;
                data_n = head.data;
                if (last_pop) state_n = IDLE;
            end
            FILL: begin
                we_n   = 1'b1;
                addr_n = ptr;
                data_n = fdat;
                ptr_n  = ptr + 1'b1;
                rem_n  = rem - 1'b1;
                if (rem == {{AW{1'b0}}, 1'b1}) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            rem       <= '0;
            fdat      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            rem       <= rem_n;
            fdat      <= fdat_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= data_n;
            fill_done <= done_n;
        end
    end

`ifdef WR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          wr_count <= '0;
        else if (mem_we && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
    end
`endif
endmodule
